// File: rtl/ifu_pc.sv
// Fetch program counter with a one-deep branch-redirect latch for stalled fetch.
// Optional macro IFU_RANGE_CHECK_EN adds an address-window check to exccode_pc.
module ifu_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [4:0]  exccode_pc,
  output logic        redir_pending
);

  localparam int unsigned XLEN     = 32;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
`ifdef IFU_RANGE_CHECK_EN
  localparam logic [XLEN-1:0] RANGE_LO = 32'h0000_3000;
  localparam logic [XLEN-1:0] RANGE_HI = 32'h0000_6FFC;
`endif

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            bad_addr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state: flush/eret override everything and drop any pending redirect
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    if (exc_flush) begin
      state_d = RUN;
      tgt_d   = '0;
      pc_d    = HANDLER_PC;
    end else if (eret) begin
      state_d = RUN;
      tgt_d   = '0;
      pc_d    = epc;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            pc_d = br_taken ? br_target : pc_q + XLEN'(4);
          end else if (br_taken) begin
            state_d = HOLD;
            tgt_d   = br_target;
          end
        end
        HOLD: begin
          // Later br_taken pulses are ignored until the held target is consumed
          if (en) begin
            state_d = RUN;
            tgt_d   = '0;
            pc_d    = tgt_q;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    redir_pending = (state_q == HOLD);
    bad_addr      = (pc_q[1:0] != 2'b00);
`ifdef IFU_RANGE_CHECK_EN
    bad_addr      = bad_addr || (pc_q < RANGE_LO) || (pc_q > RANGE_HI);
`endif
    exccode_pc    = bad_addr ? EXC_ADEL : EXC_NONE;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_ifu_pc.sv
// Bench for ifu_pc: directed vector table, async-reset-in-HOLD sequence,
// then randomized traffic against a queue-based reference model.
module tb_ifu_pc;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
`ifdef IFU_RANGE_CHECK_EN
  localparam logic [4:0] RC_BAD = 5'd4;
`else
  localparam logic [4:0] RC_BAD = 5'd0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_flush;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [4:0]  exccode_pc;
  logic        redir_pending;

  int checks = 0;
  int errors = 0;

  ifu_pc #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC)) dut (
    .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .br_target(br_target),
    .exc_flush(exc_flush), .eret(eret), .epc(epc), .pc(pc),
    .exccode_pc(exccode_pc), .redir_pending(redir_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        ert;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pend;
    logic [4:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic b, input logic [31:0] t,
                       input logic x, input logic r, input logic [31:0] p);
    en = e; br_taken = b; br_target = t; exc_flush = x; eret = r; epc = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic b, input logic [31:0] t,
                              input logic x, input logic r, input logic [31:0] p,
                              input logic [31:0] xpc, input logic xpend, input logic [4:0] xcode);
    vec_t v;
    v.en = e; v.br = b; v.tgt = t; v.exc = x; v.ert = r; v.epc = p;
    v.pc = xpc; v.pend = xpend; v.code = xcode;
    return v;
  endfunction

  // Reference: exception code straight from the address rules
  function automatic logic [4:0] ref_code(input logic [31:0] a);
    if (a % 4 != 0) return 5'd4;
`ifdef IFU_RANGE_CHECK_EN
    if (a < 32'h3000 || a > 32'h6FFC) return 5'd4;
`endif
    return 5'd0;
  endfunction

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #3 reset = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #12;
    chk("reset_pc", pc, RESET_PC);
    chk("reset_pend", 32'(redir_pending), 32'd0);
    chk("reset_code", 32'(exccode_pc), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_pc", pc, RESET_PC);

    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h3004, 0, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h3008, 0, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h300C, 0, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h3010, 0, 5'd0));
    vecs.push_back(mk(0,1,32'h3100,0,0,32'h0,   32'h3010, 1, 5'd0));
    vecs.push_back(mk(0,0,32'h0,   0,0,32'h0,   32'h3010, 1, 5'd0));
    vecs.push_back(mk(0,1,32'h3300,0,0,32'h0,   32'h3010, 1, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h3100, 0, 5'd0));
    vecs.push_back(mk(1,1,32'h3200,0,0,32'h0,   32'h3200, 0, 5'd0));
    vecs.push_back(mk(0,0,32'h0,   1,1,32'h3200,32'h4180, 0, 5'd0));
    vecs.push_back(mk(0,0,32'h0,   0,1,32'h3202,32'h3202, 0, 5'd4));
    vecs.push_back(mk(1,1,32'h7000,0,0,32'h0,   32'h7000, 0, RC_BAD));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h7004, 0, RC_BAD));
    vecs.push_back(mk(0,1,32'h3400,0,0,32'h0,   32'h7004, 1, RC_BAD));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,   32'h4180, 0, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h4184, 0, 5'd0));
    vecs.push_back(mk(0,1,32'h3500,0,0,32'h0,   32'h4184, 1, 5'd0));
    vecs.push_back(mk(0,0,32'h0,   0,1,32'h3600,32'h3600, 0, 5'd0));
    vecs.push_back(mk(1,1,32'hFFFF_FFFC,0,0,32'h0,32'hFFFF_FFFC, 0, RC_BAD));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h0000_0000, 0, RC_BAD));
    vecs.push_back(mk(0,1,32'h3700,0,0,32'h0,   32'h0000_0000, 1, RC_BAD));
    vecs.push_back(mk(1,0,32'h0,   0,1,32'h3800,32'h3800, 0, 5'd0));
    vecs.push_back(mk(1,0,32'h0,   0,0,32'h0,   32'h3804, 0, 5'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].br, vecs[i].tgt, vecs[i].exc, vecs[i].ert, vecs[i].epc);
      step();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_pend", i), 32'(redir_pending), 32'(vecs[i].pend));
      chk($sformatf("vec%0d_code", i), 32'(exccode_pc), 32'(vecs[i].code));
    end

    // Async reset while a redirect is held
    drive(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, '0);
    step();
    chk("hold_pend", 32'(redir_pending), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, RESET_PC);
    chk("async_rst_pend", 32'(redir_pending), 32'd0);
    step();
    #2 reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("after_rst_pc", pc, RESET_PC + 32'd4);
    chk("after_rst_pend", 32'(redir_pending), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    m_pc = RESET_PC;
    m_pend.delete();
    for (int n = 0; n < 400; n++) begin
      logic        r_en, r_br, r_exc, r_ert;
      logic [31:0] r_tgt, r_epc;
      r_en  = ($urandom_range(0, 9) < 6);
      r_br  = ($urandom_range(0, 9) < 3);
      r_exc = ($urandom_range(0, 29) == 0);
      r_ert = ($urandom_range(0, 19) == 0);
      r_tgt = 32'($urandom_range(32'h3000, 32'h6FFC)) & ~32'd3;
      r_epc = 32'($urandom_range(32'h3000, 32'h6FFC));
      if ($urandom_range(0, 9) == 0) r_tgt = $urandom;
      drive(r_en, r_br, r_tgt, r_exc, r_ert, r_epc);
      if (r_exc) begin
        m_pc = HANDLER_PC; m_pend.delete();
      end else if (r_ert) begin
        m_pc = r_epc; m_pend.delete();
      end else if (m_pend.size() != 0) begin
        if (r_en) m_pc = m_pend.pop_front();
      end else if (r_br) begin
        if (r_en) m_pc = r_tgt;
        else m_pend.push_back(r_tgt);
      end else if (r_en) begin
        m_pc = m_pc + 32'd4;
      end
      step();
      chk($sformatf("rnd%0d_pc", n), pc, m_pc);
      chk($sformatf("rnd%0d_pend", n), 32'(redir_pending), 32'(m_pend.size()));
      chk($sformatf("rnd%0d_code", n), 32'(exccode_pc), 32'(ref_code(m_pc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
IFU_PC -- requirements
Module: ifu_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, exception/interrupt entry address.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  advance enable; 0 = fetch stalled (same sense as downstream F/D register enable).
REQ-006 Port br_taken  input  1  branch/jump redirect request from decode, one-cycle pulse.
REQ-007 Port br_target  input  32  redirect address accompanying br_taken.
REQ-008 Port exc_flush  input  1  exception/interrupt taken; force fetch to HANDLER_PC.
REQ-009 Port eret  input  1  eret taken; redirect fetch to epc.
REQ-010 Port epc  input  32  return address from CP0.
REQ-011 Port pc  output  32  current fetch address, also drives instruction-memory address.
REQ-012 Port exccode_pc  output  5  fetch exception code for pc (0 = none, 4 = AdEL).
REQ-013 Port redir_pending  output  1  high while a branch redirect is held in the pending latch.

Function
REQ-014 Next-PC priority SHALL be: exc_flush > eret > pending redirect > br_taken > pc+4.
REQ-015 exc_flush SHALL load pc with HANDLER_PC on the next edge regardless of en, and clear the pending latch.
REQ-016 eret SHALL load pc with epc on the next edge regardless of en, and clear the pending latch.
REQ-017 With en=1 and no flush/eret, pc SHALL load the pending target if redir_pending, else br_target if br_taken, else pc+4 (32-bit, wraps modulo 2^32).
REQ-018 With en=0, pc SHALL hold its value.
REQ-019 Two-state FSM RUN/HOLD: in RUN, br_taken with en=0 SHALL latch br_target and move to HOLD (redir_pending=1).
REQ-020 In HOLD, the first edge with en=1 SHALL load the latched target into pc and return to RUN; further br_taken pulses in HOLD SHALL be ignored.
REQ-021 In RUN, br_taken with en=1 SHALL redirect directly; the FSM SHALL stay in RUN.
REQ-022 exc_flush and eret asserted together SHALL resolve to exc_flush.
REQ-023 exccode_pc SHALL be combinational from pc: 5'd4 when pc[1:0]!=2'b00, else 5'd0 (subject to REQ-027).
REQ-024 Latency: redirect visible on pc exactly one edge after the request edge (or after en rises, for HOLD).

Reset
REQ-025 While reset=1, pc SHALL be RESET_PC, FSM SHALL be RUN, redir_pending=0, pending target=0, asynchronously and independent of clk.
REQ-026 Reset asserted mid-HOLD SHALL discard the pending target; first edge after release with en=1 SHALL yield RESET_PC+4.

Configuration
REQ-027 With macro IFU_RANGE_CHECK_EN defined, exccode_pc SHALL also be 5'd4 when pc < 32'h0000_3000 or pc > 32'h0000_6FFC; without it, only the alignment check of REQ-023 applies.

Verification
REQ-028 Reset pulse, then 3 edges en=1 -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; exccode_pc=0.
REQ-029 At pc=0x3010, en=0 and br_taken=1, br_target=0x3100; hold en=0 two edges; en=1 -> redir_pending=1 during stall, pc stays 0x3010, then pc=0x3100, redir_pending=0.
REQ-030 en=0, exc_flush=1 and eret=1 same cycle with epc=0x3200 -> next pc=0x4180, redir_pending=0.
REQ-031 eret=1, epc=0x3202 -> pc=0x3202, exccode_pc=4.
REQ-032 With IFU_RANGE_CHECK_EN: br_target=0x7000 taken -> pc=0x7000, exccode_pc=4; without macro -> exccode_pc=0.
REQ-033 In HOLD with target 0x3100, assert reset asynchronously between edges -> pc=0x3000 immediately, redir_pending=0; after release one en=1 edge -> pc=0x3004.
